// File: rtl/sobel_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_sched_pkg
// Description : Shared types and constants for the sobel3 window scheduler.
//               - sched_state_e   : scheduler FSM state encoding
//               - DEFAULT_*       : default pixel / address widths
//               - win_w()         : width of a packed 3x3 window
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } sched_state_e;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_ADDR_W     = 16;
  localparam int PIXELS_PER_WINDOW  = 9;
  // Wide enough for the largest legal FETCH_TIMEOUT (65535).
  localparam int TIMEOUT_CNT_W      = 16;
  localparam int STATS_W            = 16;

  // Bits needed to carry one 3x3 window of data_width-bit pixels.
  function automatic int win_w(input int data_width);
    return data_width * PIXELS_PER_WINDOW;
  endfunction

endpackage : sobel_sched_pkg
`default_nettype wire

// File: rtl/sobel_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : sobel_rr_arb2
// Description : Two-input round-robin arbiter. The grant is combinational
//               from the request valids and the last-grant register; the
//               register advances to the winning index on accept_i.
//               The register resets to 1 so requester 0 wins first.
// Ports       : clk, rst_n       - clock, async active-low reset
//               valid_i[1:0]     - request valids
//               accept_i         - winner was accepted this cycle
//               grant_o[1:0]     - one-hot grant (zero when nobody valid)
//               last_grant_o     - index of the most recently accepted winner
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       last_grant_o
);

  logic last_grant_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Both pending: favour whoever did not win last time.
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (accept_i) begin
      last_grant_q <= grant_o[1];
    end
  end

  assign last_grant_o = last_grant_q;

endmodule : sobel_rr_arb2
`default_nettype wire

// File: rtl/sobel_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_scheduler
// Description : Serialises events from two requesters into the sobel3
//               gradient stage. Each accepted event fetches its 3x3 window
//               from window memory and hands the window to sobel3 when sobel3
//               asks for one. One event in flight at a time; the fetch is
//               abandoned (timeout_err pulse) after FETCH_TIMEOUT cycles.
// Optional    : SOBEL_SCHED_STATS_EN adds saturating evt_count / drop_count.
// Ports       : clk, rst_n                   - clock, async active-low reset
//               reqN_valid/addr/ready        - event requesters 0 and 1
//               fetch_req/addr/ack           - window read request handshake
//               fetch_rvalid/rdata           - window read data
//               sobel_window_req             - sobel3 wants a window
//               win_value/valid/addr/src     - window issued to sobel3
//               timeout_err                  - event dropped (1-cycle pulse)
//               busy                         - event in flight
//               evt_count, drop_count        - statistics (optional)
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req0_valid,
  input  logic [ADDR_W-1:0]                     req0_addr,
  output logic                                  req0_ready,
  input  logic                                  req1_valid,
  input  logic [ADDR_W-1:0]                     req1_addr,
  output logic                                  req1_ready,
  output logic                                  fetch_req,
  output logic [ADDR_W-1:0]                     fetch_addr,
  input  logic                                  fetch_ack,
  input  logic                                  fetch_rvalid,
  input  logic [DATA_WIDTH*PIXELS_PER_WINDOW-1:0] fetch_rdata,
  input  logic                                  sobel_window_req,
  output logic [DATA_WIDTH*PIXELS_PER_WINDOW-1:0] win_value,
  output logic                                  win_valid,
  output logic [ADDR_W-1:0]                     win_addr,
  output logic                                  win_src,
  output logic                                  timeout_err,
  output logic                                  busy
`ifdef SOBEL_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0]                    evt_count,
  output logic [STATS_W-1:0]                    drop_count
`endif
);

  localparam int WIN_W = win_w(DATA_WIDTH);
  localparam logic [TIMEOUT_CNT_W-1:0] C_TIMEOUT_LAST =
    TIMEOUT_CNT_W'(FETCH_TIMEOUT - 1);

  sched_state_e             state_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_d;
  logic [ADDR_W-1:0]        addr_q;
  logic [WIN_W-1:0]         rdata_q;
  logic                     fetch_req_q;
  logic [WIN_W-1:0]         win_value_q;
  logic [ADDR_W-1:0]        win_addr_q;
  logic                     win_src_q;
  logic                     win_valid_q;
  logic                     timeout_err_q;

  logic [1:0]               w_grant;
  logic                     w_last_grant;
  logic                     w_idle;
  logic                     w_accept;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic                     w_timeout;

  // --------------------------------------------------------------------------
  // Requester arbitration
  // --------------------------------------------------------------------------
  assign w_idle     = (state_q == ST_IDLE);
  assign w_accept   = w_idle && (w_grant != 2'b00);
  assign w_sel_addr = w_grant[1] ? req1_addr : req0_addr;

  sobel_rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      ({req1_valid, req0_valid}),
    .accept_i     (w_accept),
    .grant_o      (w_grant),
    .last_grant_o (w_last_grant)
  );

  assign req0_ready = w_idle && w_grant[0];
  assign req1_ready = w_idle && w_grant[1];

  // --------------------------------------------------------------------------
  // Timeout: the counter holds the number of completed FETCH/WAIT cycles, so
  // the edge that would bring it to FETCH_TIMEOUT is the one that gives up.
  // --------------------------------------------------------------------------
  assign cnt_d     = cnt_q + TIMEOUT_CNT_W'(1);
  assign w_timeout = (cnt_q == C_TIMEOUT_LAST);

  // --------------------------------------------------------------------------
  // Scheduler FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      rdata_q       <= '0;
      fetch_req_q   <= 1'b0;
      win_value_q   <= '0;
      win_addr_q    <= '0;
      win_src_q     <= 1'b0;
      win_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      win_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            addr_q      <= w_sel_addr;
            cnt_q       <= '0;
            fetch_req_q <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          cnt_q <= cnt_d;
          if (w_timeout) begin
            fetch_req_q   <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else if (fetch_ack) begin
            fetch_req_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          cnt_q <= cnt_d;
          // Data arriving on the expiry edge still counts as a success.
          if (fetch_rvalid) begin
            rdata_q <= fetch_rdata;
            state_q <= ST_ISSUE;
          end else if (w_timeout) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (sobel_window_req) begin
            win_value_q <= rdata_q;
            win_addr_q  <= addr_q;
            // The arbiter only moves on accept in IDLE, so its last-grant
            // register still names the source of the event in flight.
            win_src_q   <= w_last_grant;
            win_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_addr  = addr_q;
  assign win_value   = win_value_q;
  assign win_valid   = win_valid_q;
  assign win_addr    = win_addr_q;
  assign win_src     = win_src_q;
  assign timeout_err = timeout_err_q;
  assign busy        = !w_idle;

  // --------------------------------------------------------------------------
  // Optional saturating statistics
  // --------------------------------------------------------------------------
`ifdef SOBEL_SCHED_STATS_EN
  logic [STATS_W-1:0] evt_count_q;
  logic [STATS_W-1:0] drop_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (win_valid_q && (evt_count_q != '1)) begin
        evt_count_q <= evt_count_q + STATS_W'(1);
      end
      if (timeout_err_q && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + STATS_W'(1);
      end
    end
  end

  assign evt_count  = evt_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule : sobel_window_scheduler
`default_nettype wire

// File: doc/sobel_window_scheduler.md
Name: sobel_window_scheduler

Overview:
- Sequences events into the sobel3 gradient stage.
- Accepts event addresses from two requesters (positive and negative polarity event streams) and shares the window-fetch port and sobel3 between them by round-robin arbitration.
- For each granted event: fetches the 3x3 window, then issues the window to sobel3 only while sobel3 asks for one.
- Sits between the event input FIFOs and the window memory / sobel3 pair.

Parameters:
- DATA_WIDTH, 4: bits per pixel of the window.
- ADDR_W, 16: event/window address width.
- FETCH_TIMEOUT, 255: maximum cycles spent in FETCH+WAIT before the event is dropped; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 event valid
- req0_addr  in  ADDR_W  requester 0 event address
- req0_ready  out  1  requester 0 accept
- req1_valid  in  1  requester 1 event valid
- req1_addr  in  ADDR_W  requester 1 event address
- req1_ready  out  1  requester 1 accept
- fetch_req  out  1  window read request (level)
- fetch_addr  out  ADDR_W  window read address
- fetch_ack  in  1  memory accepted fetch_req
- fetch_rvalid  in  1  window data valid
- fetch_rdata  in  DATA_WIDTH*9  3x3 window, pixel k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- sobel_window_req  in  1  sobel3 ready for a new window
- win_value  out  DATA_WIDTH*9  window to sobel3
- win_valid  out  1  one-cycle window strobe to sobel3
- win_addr  out  ADDR_W  event address to sobel3
- win_src  out  1  requester index of the issued window
- timeout_err  out  1  one-cycle pulse when an event is dropped
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, last_grant=1 (so req0 wins first), timeout counter=0, all registered outputs 0.
- States: IDLE, FETCH, WAIT, ISSUE.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, and only for the grant winner.
  - Winner: the sole valid requester; if both are valid, the requester != last_grant.
  - On valid&ready: latch addr and source, update last_grant, go to FETCH.
- FETCH:
  - fetch_req=1 and fetch_addr=latched addr, both held stable until fetch_ack is sampled high.
  - On fetch_ack: go to WAIT.
- WAIT:
  - On fetch_rvalid: latch fetch_rdata, go to ISSUE.
  - fetch_rvalid is ignored in every other state.
- ISSUE:
  - Wait for sobel_window_req=1.
  - At that edge, register win_value, win_addr, win_src and set win_valid=1 for exactly one cycle; go to IDLE.
  - win_value, win_addr and win_src then hold until the next issue.
- Timeout:
  - Counter clears on entry to FETCH and increments every cycle in FETCH or WAIT.
  - When it reaches FETCH_TIMEOUT without fetch_rvalid: pulse timeout_err one cycle, drop fetch_req, go to IDLE.
  - fetch_rvalid arriving on the same edge as timeout wins: the event proceeds and there is no error.
- Latency: accept at edge 0 with immediate fetch_ack and fetch_rvalid one cycle later, and sobel_window_req high -> win_valid high in the cycle after edge 3. Minimum 4 cycles.
- Throughput: at most one event in flight; new requests are refused outside IDLE.
- busy is combinational from state.

Optional Feature:
- Macro: SOBEL_SCHED_STATS_EN.
- When defined, adds two output ports:
  - evt_count (16-bit): increments on each win_valid.
  - drop_count (16-bit): increments on each timeout_err.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package sobel_sched_pkg holds:
  - state enum (IDLE/FETCH/WAIT/ISSUE)
  - default DATA_WIDTH and ADDR_W
  - WIN_W = DATA_WIDTH*9 helper
- One sub-module, sobel_rr_arb2: a 2-input round-robin arbiter.
  - Inputs: valids, last_grant, accept strobe.
  - Outputs: one-hot grant and the updated last_grant register.
- The FSM, timeout counter and output registers stay in the top module.

Test Plan:
- Reset mid-WAIT: assert rst_n low -> all outputs 0, busy=0, state IDLE; next request is served from req0.
- Single event: req0 addr 0x1234, fetch_ack on the first FETCH cycle, fetch_rvalid one cycle later with rdata 0x123456789, sobel_window_req=1 -> win_valid one cycle, 4 cycles after accept; win_addr=0x1234, win_value=0x123456789, win_src=0.
- Contention: req0 and req1 both held valid with addrs 0x0010 and 0x0020 -> grants alternate 0,1,0,1; win_addr sequence 0x0010, 0x0020, 0x0010, 0x0020.
- Backpressure: sobel_window_req low for 5 cycles in ISSUE -> win_valid stays 0, req ready stays 0, busy=1; win_valid fires on the edge sobel_window_req rises.
- Timeout with FETCH_TIMEOUT=8: fetch_ack given, no rvalid -> timeout_err pulses once at cycle 8 after entering FETCH, fetch_req=0, returns to IDLE, next event served normally. With SOBEL_SCHED_STATS_EN, drop_count=1.
- Timeout tie: fetch_rvalid on the same edge the counter hits FETCH_TIMEOUT -> no timeout_err, window issued.
